counter8_seq: RTL and testbench
===============================

Name: counter8_seq

Overview:
Command sequencer for the 8-bit universal up/down counter datapath. It accepts LOAD/CLEAR/UP/DOWN commands over a valid/ready handshake and drives the counter's preload, direction, wrap/stop and count-enable controls for an exact number of cycles. It monitors the counter output to end a stop-mode run early at the boundary, and reports completion. It sits between the host control logic and the counter core.

Parameters:
WIDTH, 8, counter data width; also the width of the step-count argument
MAXVAL, 2**WIDTH-1, counter terminal value used for the stop-mode upper bound

Ports:
clk  in  1  single clock, rising edge
_areset  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept (high only in IDLE)
cmd_op  in  2  00=LOAD, 01=UP, 10=DOWN, 11=CLEAR
cmd_arg  in  WIDTH  preload value (LOAD) or step count (UP/DOWN); ignored for CLEAR
cmd_wrap  in  1  1=wrap mode, 0=stop mode (UP/DOWN only)
abort  in  1  synchronous run abort
ctr_dcout  in  WIDTH  counter current value
_ctr_load  out  1  active-low preload strobe to counter
ctr_preld  out  WIDTH  preload value to counter
_ctr_updown  out  1  1=up, 0=down
_ctr_wrapstop  out  1  1=wrap, 0=stop
ctr_en  out  1  counter advances one step on each clk with ctr_en=1
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse
ovf_stop  out  1  sticky: last run ended at a stop-mode boundary
steps_left  out  WIDTH  remaining steps in the current run

Behaviour:
- Reset (async, _areset=0): state IDLE; _ctr_load=1, ctr_preld=0, _ctr_updown=1, _ctr_wrapstop=1, ctr_en=0, busy=0, done=0, ovf_stop=0, steps_left=0. A reset during a run takes effect immediately; there is no done pulse.
- FSM states: IDLE, LOAD, RUN, DONE. cmd_ready = (state==IDLE). A command is accepted on a clk edge with cmd_valid&cmd_ready. An accept clears ovf_stop and registers op, arg and wrap.
- LOAD/CLEAR: IDLE->LOAD. LOAD lasts exactly 1 cycle with _ctr_load=0 and ctr_preld=arg (CLEAR: 0). Then DONE.
- UP/DOWN, arg=0: IDLE->DONE with no ctr_en cycle.
- UP/DOWN, arg>0: IDLE->RUN. In RUN: ctr_en=1; _ctr_updown=(op==UP); _ctr_wrapstop=wrap; steps_left loads arg and decrements once per RUN cycle. RUN->DONE on the edge where steps_left==1, so ctr_en is high for exactly arg cycles.
- Stop-mode early exit (wrap=0): during RUN, if (UP and ctr_dcout==MAXVAL) or (DOWN and ctr_dcout==0), then ctr_en=0 that cycle (combinational), ovf_stop<=1, and the FSM goes to DONE. Wrap mode never exits early; the counter wraps modulo 2**WIDTH.
- abort=1 in RUN: ctr_en=0 that cycle, then DONE. Early exit takes priority over abort for ovf_stop. abort is ignored in other states.
- DONE: lasts 1 cycle with done=1, then IDLE. Control outputs return to their idle values (_ctr_load=1, ctr_en=0); _ctr_updown and _ctr_wrapstop hold their last values.
- Latency: LOAD accepted at edge N -> _ctr_load low during cycle N+1, done high during cycle N+2, cmd_ready high at N+3. UP n: ctr_en high in cycles N+1..N+n, done in cycle N+n+1.
- cmd_valid while busy: not accepted; the command must be held by the host.
- steps_left is 0 outside RUN.

Decomposition:
- Shared package: opcode constants (OP_LOAD, OP_UP, OP_DOWN, OP_CLEAR), state encodings, WIDTH default.
- One natural sub-module: counter8_seq_stepctr, a down-counter for steps_left (load, dec, zero/one flags).
- The counter core is not instantiated inside this block; the top level connects them.

Test Plan:
- Reset, then LOAD arg=8'h5A -> _ctr_load=0 for exactly 1 cycle with ctr_preld=8'h5A; done pulse 1 cycle later; ovf_stop=0.
- UP arg=3, wrap=1, counter at 8'hFE -> ctr_en high 3 cycles; counter 8'hFE->8'hFF->8'h00->8'h01; done after; ovf_stop=0.
- UP arg=10, wrap=0, counter at 8'hFC -> ctr_en high 3 cycles, deasserted when dcout=8'hFF; ovf_stop=1; done pulse; steps_left reads 7 at exit.
- DOWN arg=5, wrap=0, counter at 8'h02 -> stops at 8'h00 after 2 enables, ovf_stop=1; the next accepted command clears ovf_stop.
- UP arg=200, abort asserted in the 4th RUN cycle -> ctr_en high for 3 cycles only; done next cycle; cmd_valid held throughout RUN is not accepted until IDLE.
- UP arg=50, _areset pulsed low mid-RUN -> all outputs reach their reset values immediately, no done pulse, cmd_ready=1 after release.

Source files
------------

// File: rtl/counter8_seq_pkg.sv
// rtl/counter8_seq_pkg.sv - shared opcodes, state encoding and default width for counter8_seq
package counter8_seq_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_UP    = 2'b01;
    localparam logic [1:0] OP_DOWN  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

endpackage

// File: rtl/counter8_seq_stepctr.sv
// rtl/counter8_seq_stepctr.sv - loadable down-counter holding the remaining step count
module counter8_seq_stepctr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] count_o,
    output logic             zero_o,
    output logic             one_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Clear wins over load, load wins over decrement; never decrement below zero.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // Step count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);
    assign one_o   = (count_q == WIDTH'(1));

endmodule

// File: rtl/counter8_seq.sv
// rtl/counter8_seq.sv - command sequencer driving the up/down counter controls
module counter8_seq
    import counter8_seq_pkg::*;
#(
    parameter int               WIDTH  = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] MAXVAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             _areset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    input  logic             cmd_wrap,
    input  logic             abort,
    input  logic [WIDTH-1:0] ctr_dcout,
    output logic             _ctr_load,
    output logic [WIDTH-1:0] ctr_preld,
    output logic             _ctr_updown,
    output logic             _ctr_wrapstop,
    output logic             ctr_en,
    output logic             busy,
    output logic             done,
    output logic             ovf_stop,
    output logic [WIDTH-1:0] steps_left
);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] arg_q;
    logic             ovf_q;
    logic             updown_q;
    logic             wrapstop_q;

    logic             accept;
    logic             is_cnt_op;
    logic             arg_zero;
    logic             in_run;
    logic             at_bound;
    logic             early_exit;
    logic             run_abort;
    logic             step_load;
    logic             step_dec;
    logic             step_clr;
    logic             step_zero;
    logic             step_one;

    assign accept     = cmd_valid && (state_q == ST_IDLE);
    assign is_cnt_op  = (cmd_op == OP_UP) || (cmd_op == OP_DOWN);
    assign arg_zero   = (cmd_arg == '0);
    assign in_run     = (state_q == ST_RUN);

    // The run direction and mode are latched on entry to RUN, so they are
    // valid for the whole run.
    assign at_bound   = updown_q ? (ctr_dcout == MAXVAL) : (ctr_dcout == '0);
    assign early_exit = in_run && !wrapstop_q && at_bound;
    assign run_abort  = in_run && abort;

    assign step_load  = accept && is_cnt_op && !arg_zero;
    assign step_dec   = in_run && !step_zero;
    assign step_clr   = early_exit || run_abort;

    counter8_seq_stepctr #(
        .WIDTH (WIDTH)
    ) u_stepctr (
        .clk        (clk),
        .rst_n      (_areset),
        .load_i     (step_load),
        .load_val_i (cmd_arg),
        .dec_i      (step_dec),
        .clr_i      (step_clr),
        .count_o    (steps_left),
        .zero_o     (step_zero),
        .one_o      (step_one)
    );

    // Next state and the combinational counter controls.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        _ctr_load = 1'b1;
        ctr_preld = '0;
        ctr_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (accept) begin
                    if (!is_cnt_op) begin
                        state_d = ST_LOAD;
                    end else if (arg_zero) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_LOAD: begin
                _ctr_load = 1'b0;
                ctr_preld = arg_q;
                state_d   = ST_DONE;
            end
            ST_RUN: begin
                ctr_en = !early_exit && !run_abort;
                if (early_exit || run_abort || step_one) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge _areset) begin
        if (!_areset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command capture, sticky boundary flag and held direction/mode.
    always_ff @(posedge clk or negedge _areset) begin
        if (!_areset) begin
            arg_q      <= '0;
            ovf_q      <= 1'b0;
            updown_q   <= 1'b1;
            wrapstop_q <= 1'b1;
        end else if (accept) begin
            arg_q <= (cmd_op == OP_CLEAR) ? '0 : cmd_arg;
            ovf_q <= 1'b0;
            if (step_load) begin
                updown_q   <= (cmd_op == OP_UP);
                wrapstop_q <= cmd_wrap;
            end
        end else if (early_exit) begin
            ovf_q <= 1'b1;
        end
    end

    assign _ctr_updown   = updown_q;
    assign _ctr_wrapstop = wrapstop_q;
    assign ovf_stop      = ovf_q;

endmodule

// File: tb/tb_counter8_seq.sv
// tb/tb_counter8_seq.sv - directed self-checking bench for counter8_seq
module tb_counter8_seq;

    typedef struct {
        logic       rst;
        logic       valid;
        logic [1:0] op;
        logic [7:0] arg;
        logic       wrap;
        logic       abort;
        logic       ready;
        logic       busy;
        logic       done;
        logic       ld_n;
        logic       en;
        logic       ud;
        logic       ws;
        logic       ovf;
        logic [7:0] preld;
        logic [7:0] steps;
        logic [7:0] cnt;
    } vec_t;

    typedef struct {
        string name;
        int    act;
        int    exp;
    } pin_t;

    localparam logic [1:0] LD = 2'b00, UP = 2'b01, DN = 2'b10, CL = 2'b11;

    logic       clk = 1'b0;
    logic       areset_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_arg = 8'h00;
    logic       cmd_wrap = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] cnt_q = 8'h00;
    logic       ctr_load_n;
    logic [7:0] ctr_preld;
    logic       ctr_updown;
    logic       ctr_wrapstop;
    logic       ctr_en;
    logic       busy;
    logic       done;
    logic       ovf_stop;
    logic [7:0] steps_left;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    vec_t plan[$];
    vec_t chk_q[$];
    pin_t pin_q[$];

    // Model state: counter value, sticky flag, held direction/mode, held command.
    logic [7:0] mcnt = 8'h00;
    logic       movf = 1'b0;
    logic       mupd = 1'b1;
    logic       mwrp = 1'b1;
    logic       hv   = 1'b0;
    logic [1:0] hop  = 2'b00;
    logic [7:0] harg = 8'h00;
    int         m_en;
    int         m_exit;

    always #5 clk = ~clk;

    counter8_seq dut (
        .clk           (clk),
        ._areset       (areset_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_arg       (cmd_arg),
        .cmd_wrap      (cmd_wrap),
        .abort         (abort),
        .ctr_dcout     (cnt_q),
        ._ctr_load     (ctr_load_n),
        .ctr_preld     (ctr_preld),
        ._ctr_updown   (ctr_updown),
        ._ctr_wrapstop (ctr_wrapstop),
        .ctr_en        (ctr_en),
        .busy          (busy),
        .done          (done),
        .ovf_stop      (ovf_stop),
        .steps_left    (steps_left)
    );

    // Behavioural counter core attached to the sequencer outputs.
    always @(posedge clk) begin
        if (!ctr_load_n) cnt_q <= ctr_preld;
        else if (ctr_en) cnt_q <= ctr_updown ? cnt_q + 8'd1 : cnt_q - 8'd1;
    end

    function automatic vec_t idle_vec();
        vec_t v;
        v.rst = 1'b0; v.valid = hv; v.op = hop; v.arg = harg; v.wrap = 1'b0; v.abort = 1'b0;
        v.ready = 1'b1; v.busy = 1'b0; v.done = 1'b0; v.ld_n = 1'b1; v.en = 1'b0;
        v.ud = mupd; v.ws = mwrp; v.ovf = movf; v.preld = 8'h00; v.steps = 8'h00; v.cnt = mcnt;
        return v;
    endfunction

    function automatic vec_t busy_vec();
        vec_t v;
        v = idle_vec();
        v.ready = 1'b0;
        v.busy  = 1'b1;
        return v;
    endfunction

    task automatic push_idle(input int n);
        repeat (n) plan.push_back(idle_vec());
    endtask

    task automatic push_reset(input int n);
        vec_t v;
        movf = 1'b0; mupd = 1'b1; mwrp = 1'b1;
        v = idle_vec();
        v.rst = 1'b1;
        v.valid = 1'b0;
        repeat (n) plan.push_back(v);
    endtask

    task automatic pin(input string nm, input int a, input int e);
        pin_t p;
        p.name = nm; p.act = a; p.exp = e;
        pin_q.push_back(p);
    endtask

    // Builds the expected cycle trace of one command from the accept cycle onward.
    task automatic cmd(input logic [1:0] op, input logic [7:0] arg, input logic wrap,
                       input int abort_at, input int rst_at);
        vec_t v;
        logic bound;
        v = idle_vec();
        v.valid = 1'b1; v.op = op; v.arg = arg; v.wrap = wrap;
        plan.push_back(v);
        movf = 1'b0; m_en = 0; m_exit = -1;
        if (op == LD || op == CL) begin
            v = busy_vec();
            v.ld_n = 1'b0;
            v.preld = (op == CL) ? 8'h00 : arg;
            plan.push_back(v);
            mcnt = v.preld;
        end else if (arg != 8'h00) begin
            mupd = (op == UP);
            mwrp = wrap;
            for (int r = 1; r <= int'(arg); r++) begin
                if (r == rst_at) begin
                    push_reset(1);
                    return;
                end
                v = busy_vec();
                v.steps = 8'(int'(arg) - r + 1);
                v.abort = (r == abort_at);
                bound = !wrap && (mupd ? (mcnt == 8'hFF) : (mcnt == 8'h00));
                v.en = !bound && !v.abort;
                plan.push_back(v);
                if (bound) begin
                    movf = 1'b1;
                    m_exit = int'(v.steps);
                    break;
                end
                if (v.abort) begin
                    m_exit = int'(v.steps);
                    break;
                end
                m_en++;
                mcnt = mupd ? mcnt + 8'd1 : mcnt - 8'd1;
            end
        end
        v = busy_vec();
        v.done = 1'b1;
        plan.push_back(v);
    endtask

    task automatic chk(input string nm, input int a, input int e);
        if (a != e) begin
            n_err++;
            $display("FAIL cyc%0d %s: got %0d, expected %0d", cyc, nm, a, e);
        end
    endtask

    // Single compare process: model pins first, then the expected vector of this cycle.
    always @(negedge clk) begin
        pin_t p;
        vec_t e;
        while (pin_q.size() > 0) begin
            p = pin_q.pop_front();
            n_vec++;
            chk(p.name, p.act, p.exp);
        end
        if (chk_q.size() > 0) begin
            e = chk_q.pop_front();
            n_vec++;
            chk("cmd_ready",  int'(cmd_ready),    int'(e.ready));
            chk("busy",       int'(busy),         int'(e.busy));
            chk("done",       int'(done),         int'(e.done));
            chk("ctr_load_n", int'(ctr_load_n),   int'(e.ld_n));
            chk("ctr_preld",  int'(ctr_preld),    int'(e.preld));
            chk("ctr_en",     int'(ctr_en),       int'(e.en));
            chk("updown",     int'(ctr_updown),   int'(e.ud));
            chk("wrapstop",   int'(ctr_wrapstop), int'(e.ws));
            chk("ovf_stop",   int'(ovf_stop),     int'(e.ovf));
            chk("steps_left", int'(steps_left),   int'(e.steps));
            chk("ctr_value",  int'(cnt_q),        int'(e.cnt));
            cyc++;
        end
    end

    initial begin
        vec_t v;
        push_reset(3);
        push_idle(2);

        cmd(LD, 8'h5A, 1'b0, 0, 0);
        pin("load_5a_value", int'(mcnt), 'h5A);
        push_idle(1);

        cmd(LD, 8'hFE, 1'b0, 0, 0);
        cmd(UP, 8'd3, 1'b1, 0, 0);
        pin("wrap_en_cycles", m_en, 3);
        pin("wrap_final", int'(mcnt), 'h01);
        pin("wrap_ovf", int'(movf), 0);

        cmd(LD, 8'hFC, 1'b0, 0, 0);
        cmd(UP, 8'd10, 1'b0, 0, 0);
        pin("stopup_en_cycles", m_en, 3);
        pin("stopup_exit_steps", m_exit, 7);
        pin("stopup_final", int'(mcnt), 'hFF);
        pin("stopup_ovf", int'(movf), 1);

        cmd(LD, 8'h02, 1'b0, 0, 0);
        cmd(DN, 8'd5, 1'b0, 0, 0);
        pin("stopdn_en_cycles", m_en, 2);
        pin("stopdn_final", int'(mcnt), 0);
        pin("stopdn_ovf", int'(movf), 1);
        push_idle(1);
        cmd(CL, 8'h77, 1'b0, 0, 0);
        pin("clear_ovf", int'(movf), 0);

        hv = 1'b1; hop = LD; harg = 8'h33;
        cmd(UP, 8'd200, 1'b1, 4, 0);
        pin("abort_en_cycles", m_en, 3);
        pin("abort_exit_steps", m_exit, 197);
        hv = 1'b0;
        cmd(LD, 8'h33, 1'b0, 0, 0);

        cmd(UP, 8'd0, 1'b0, 0, 0);
        pin("zero_arg_en", m_en, 0);

        cmd(UP, 8'd50, 1'b1, 0, 10);
        push_idle(2);

        while (plan.size() > 0) begin
            v = plan.pop_front();
            @(posedge clk);
            #1;
            areset_n  = !v.rst;
            cmd_valid = v.valid;
            cmd_op    = v.op;
            cmd_arg   = v.arg;
            cmd_wrap  = v.wrap;
            abort     = v.abort;
            chk_q.push_back(v);
        end
        repeat (3) @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
